fifo_control: RTL and testbench

Pointer and flag controller for the transaction-layer FIFO. Converts upstream `push` and downstream `pop` requests into `write_enable`, `read_enable`, `wr_ptr` and `rd_ptr` for the `memoria` storage block. It tracks occupancy, produces full, empty and threshold flags, a sticky error, and a valid strobe aligned with `memoria`'s registered `FIFO_data_out`.

---
 rtl/fifo_pkg.sv | 15 +
 rtl/fifo_ptr.sv | 24 ++
 rtl/fifo_control.sv | 91 +++++++++
 tb/tb_fifo_control.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared sizing constants for the transaction-layer FIFO controller.
// No logic; no latency; no backpressure.
// Consumers import fifo_pkg::* for defaults and the count width helper.
package fifo_pkg;

   localparam int FIFO_DEPTH      = 8;
   localparam int FIFO_ADDR_WIDTH = 8;
   localparam int FIFO_CNT_WIDTH  = 9;

   // Minimum width able to hold the values 0..depth inclusive.
   function automatic int cnt_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Wrap-at-DEPTH address pointer, advanced by one on each inc.
// Latency: registered, new value visible the cycle after inc.
// Backpressure: none; the caller gates inc with its accept condition.
module fifo_ptr #(
   parameter int DEPTH      = 8,
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  inc,
   output logic [ADDR_WIDTH-1:0] ptr
);

   localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);

   always_ff @(posedge clk) begin
      if (reset) begin
         ptr <= '0;
      end else if (inc) begin
         ptr <= (ptr == LAST) ? '0 : ptr + 1'b1;
      end
   end

endmodule

// File: rtl/fifo_control.sv
// Pointer, occupancy and flag controller driving the memoria storage block.
// Latency: enables combinational, pointers/count registered, data_valid one cycle after read.
// Backpressure: push refused when full unless popped in the same cycle; pop refused when empty.
module fifo_control
   import fifo_pkg::*;
#(
   parameter int DEPTH      = FIFO_DEPTH,
   parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH,
   parameter int CNT_WIDTH  = FIFO_CNT_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  push,
   input  logic                  pop,
   input  logic [CNT_WIDTH-1:0]  af_thresh,
   input  logic [CNT_WIDTH-1:0]  ae_thresh,
   output logic                  write_enable,
   output logic                  read_enable,
   output logic [ADDR_WIDTH-1:0] wr_ptr,
   output logic [ADDR_WIDTH-1:0] rd_ptr,
   output logic [CNT_WIDTH-1:0]  count,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic                  error,
   output logic                  data_valid
);

   generate
      if (CNT_WIDTH < cnt_width(DEPTH)) begin : g_bad_cnt_width
         $error("fifo_control: CNT_WIDTH too narrow for DEPTH");
      end
   endgenerate

   localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(DEPTH);

   assign full         = (count == CNT_FULL);
   assign empty        = (count == '0);
   assign almost_full  = (count >= af_thresh);
   assign almost_empty = (count <= ae_thresh);

   // A pop frees the slot the simultaneous push lands in, so full does not block it.
   assign read_enable  = pop & ~empty & ~reset;
   assign write_enable = push & (~full | pop) & ~reset;

   fifo_ptr #(
      .DEPTH      (DEPTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_wr_ptr (
      .clk   (clk),
      .reset (reset),
      .inc   (write_enable),
      .ptr   (wr_ptr)
   );

   fifo_ptr #(
      .DEPTH      (DEPTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_rd_ptr (
      .clk   (clk),
      .reset (reset),
      .inc   (read_enable),
      .ptr   (rd_ptr)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
      end else begin
         case ({write_enable, read_enable})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         error      <= 1'b0;
         data_valid <= 1'b0;
      end else begin
         if ((push & full & ~pop) | (pop & empty)) begin
            error <= 1'b1;
         end
         data_valid <= read_enable;
      end
   end

endmodule

// File: tb/tb_fifo_control.sv
// Directed bench for fifo_control with a behavioural memoria and a data scoreboard.
module tb_fifo_control;

   logic        clk = 1'b0;
   logic        reset;
   logic        push;
   logic        pop;
   logic [8:0]  af_thresh;
   logic [8:0]  ae_thresh;
   logic        write_enable;
   logic        read_enable;
   logic [7:0]  wr_ptr;
   logic [7:0]  rd_ptr;
   logic [8:0]  count;
   logic        full;
   logic        empty;
   logic        almost_full;
   logic        almost_empty;
   logic        error;
   logic        data_valid;

   logic [11:0] din;
   logic [11:0] dout;
   logic [11:0] mem [256];

   int total = 0;
   int bad   = 0;
   int nvalid = 0;
   int npops  = 0;

   logic [11:0] mq [$];
   logic [11:0] exp_q [$];
   int  mcnt;
   int  mwp;
   int  mrp;
   logic merr;

   always #5 clk = ~clk;

   fifo_control dut (
      .clk          (clk),
      .reset        (reset),
      .push         (push),
      .pop          (pop),
      .af_thresh    (af_thresh),
      .ae_thresh    (ae_thresh),
      .write_enable (write_enable),
      .read_enable  (read_enable),
      .wr_ptr       (wr_ptr),
      .rd_ptr       (rd_ptr),
      .count        (count),
      .full         (full),
      .empty        (empty),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .error        (error),
      .data_valid   (data_valid)
   );

   // memoria stand-in: registered read returns the pre-write contents on a same-edge collision
   always @(posedge clk) begin
      if (write_enable) mem[wr_ptr] <= din;
      if (read_enable)  dout <= mem[rd_ptr];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (data_valid === 1'b1) begin
         logic [11:0] e;
         nvalid++;
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_data_valid: got dout %0h want no strobe at %0t", dout, $time);
         end else begin
            e = exp_q.pop_front();
            if (dout !== e) begin
               bad++;
               $display("FAIL read_data: got %0h want %0h at %0t", dout, e, $time);
            end
         end
      end
   end

   task automatic check_state(input string tag);
      chk({tag, "_count"}, 32'(count), 32'(mcnt));
      chk({tag, "_error"}, 32'(error), 32'(merr));
      chk({tag, "_full"},  32'(full),  32'(mcnt == 8));
      chk({tag, "_empty"}, 32'(empty), 32'(mcnt == 0));
      chk({tag, "_af"},    32'(almost_full),  32'(mcnt >= int'(af_thresh)));
      chk({tag, "_ae"},    32'(almost_empty), 32'(mcnt <= int'(ae_thresh)));
      chk({tag, "_wrptr"}, 32'(wr_ptr), 32'(mwp));
      chk({tag, "_rdptr"}, 32'(rd_ptr), 32'(mrp));
   endtask

   // One cycle of push/pop; starts and ends 1 time unit after a rising edge.
   task automatic op(input logic p, input logic q, input logic [11:0] d);
      logic racc, wacc;
      push = p; pop = q; din = d;
      #1;
      racc = q && (mcnt != 0);
      wacc = p && ((mcnt != 8) || q);
      chk("write_enable", 32'(write_enable), 32'(wacc));
      chk("read_enable",  32'(read_enable),  32'(racc));
      if ((p && mcnt == 8 && !q) || (q && mcnt == 0)) merr = 1'b1;
      if (racc) begin
         exp_q.push_back(mq.pop_front());
         npops++;
         mrp = (mrp + 1) % 8;
         mcnt--;
      end
      if (wacc) begin
         mq.push_back(d);
         mwp = (mwp + 1) % 8;
         mcnt++;
      end
      @(posedge clk); #1;
      push = 1'b0; pop = 1'b0;
      check_state("op");
   endtask

   task automatic do_reset(input logic p, input logic q);
      reset = 1'b1; push = p; pop = q; din = 12'hfff;
      #1;
      chk("rst_write_enable", 32'(write_enable), 32'd0);
      chk("rst_read_enable",  32'(read_enable),  32'd0);
      @(posedge clk); #1;
      reset = 1'b0; push = 1'b0; pop = 1'b0;
      mq.delete();
      mcnt = 0; mwp = 0; mrp = 0; merr = 1'b0;
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_full",  32'(full),  32'd0);
      chk("rst_ae",    32'(almost_empty), 32'd1);
      chk("rst_af",    32'(almost_full),  32'(af_thresh == 9'd0));
      chk("rst_wrptr", 32'(wr_ptr), 32'd0);
      chk("rst_rdptr", 32'(rd_ptr), 32'd0);
      chk("rst_error", 32'(error),  32'd0);
      chk("rst_dvalid", 32'(data_valid), 32'd0);
   endtask

   initial begin
      af_thresh = 9'd6; ae_thresh = 9'd2;
      push = 1'b0; pop = 1'b0; din = '0;
      mcnt = 0; mwp = 0; mrp = 0; merr = 1'b0;
      do_reset(1'b1, 1'b1);

      // Fill to full, watching thresholds; almost_empty drops at 3, almost_full rises at 6.
      for (int i = 1; i <= 8; i++) begin
         op(1'b1, 1'b0, 12'(i));
         chk("fill_count", 32'(count), 32'(i));
         chk("fill_ae", 32'(almost_empty), 32'(i <= 2));
         chk("fill_af", 32'(almost_full),  32'(i >= 6));
      end
      chk("full_flag", 32'(full), 32'd1);
      chk("full_wrptr_wrap", 32'(wr_ptr), 32'd0);

      // Threshold inputs act immediately.
      af_thresh = 9'd9; #1;
      chk("af_follow_thresh", 32'(almost_full), 32'd0);
      af_thresh = 9'd6; #1;
      chk("af_restore_thresh", 32'(almost_full), 32'd1);
      @(posedge clk); #1;

      op(1'b1, 1'b0, 12'h009);
      chk("overflow_error", 32'(error), 32'd1);
      chk("overflow_count", 32'(count), 32'd8);

      for (int i = 0; i < 8; i++) op(1'b0, 1'b1, 12'h0);
      chk("drain_empty", 32'(empty), 32'd1);
      chk("drain_rdptr_wrap", 32'(rd_ptr), 32'd0);

      do_reset(1'b0, 1'b0);
      op(1'b0, 1'b1, 12'h0);
      chk("underflow_error", 32'(error), 32'd1);
      chk("underflow_count", 32'(count), 32'd0);

      // Push and pop together at full: old head comes back.
      do_reset(1'b0, 1'b0);
      for (int i = 0; i < 8; i++) op(1'b1, 1'b0, 12'h011 + 12'(i));
      op(1'b1, 1'b1, 12'h019);
      chk("full_pp_count", 32'(count), 32'd8);
      chk("full_pp_wrptr", 32'(wr_ptr), 32'd1);
      chk("full_pp_rdptr", 32'(rd_ptr), 32'd1);
      chk("full_pp_error", 32'(error), 32'd0);
      for (int i = 0; i < 8; i++) op(1'b0, 1'b1, 12'h0);

      // Push and pop together at empty.
      op(1'b1, 1'b1, 12'h020);
      chk("empty_pp_count", 32'(count), 32'd1);
      chk("empty_pp_error", 32'(error), 32'd1);

      // Steady-state wrap-around at count 4.
      do_reset(1'b0, 1'b0);
      for (int i = 0; i < 4; i++) op(1'b1, 1'b0, 12'h100 + 12'(i));
      for (int i = 0; i < 20; i++) begin
         op(1'b1, 1'b1, 12'h104 + 12'(i));
         chk("wrap_count", 32'(count), 32'd4);
         chk("wrap_wrptr", 32'(wr_ptr), 32'((5 + i) % 8));
         chk("wrap_rdptr", 32'(rd_ptr), 32'((1 + i) % 8));
      end
      chk("wrap_error", 32'(error), 32'd0);

      // Mid-stream reset with requests pending.
      op(1'b1, 1'b0, 12'h200);
      chk("pre_reset_count", 32'(count), 32'd5);
      do_reset(1'b1, 1'b1);

      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      chk("data_valid_pulses", 32'(nvalid), 32'(npops));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
